// File: rtl/lz77_encoder.sv
// Streaming LZ77 encoder: buffers up to 8 look-ahead chars and scans a 9-entry search
// buffer one position per cycle, emitting one (pos, len, char) codeword per match.
module lz77_encoder #(
    parameter int                DATA_W       = 8,
    parameter int                SEARCH_DEPTH = 9,
    parameter int                LA_DEPTH     = 8,
    parameter logic [DATA_W-1:0] TERM_CHAR    = 8'h24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] chardata_in,
    output logic              in_ready,
    output logic              out_valid,
    output logic [3:0]        code_pos,
    output logic [2:0]        code_len,
    output logic [DATA_W-1:0] chardata,
    output logic              finish
);
    localparam int SB_IW   = $clog2(SEARCH_DEPTH);
    localparam int LA_IW   = $clog2(LA_DEPTH);
    localparam int SB_CW   = $clog2(SEARCH_DEPTH + 1);
    localparam int LA_CW   = $clog2(LA_DEPTH + 1);
    localparam int MAX_LEN = LA_DEPTH - 1;

    typedef enum logic [2:0] {ST_FILL, ST_SEARCH, ST_EMIT, ST_SHIFT, ST_DONE} state_t;

    state_t            r_state, w_stateNext;
    logic [DATA_W-1:0] r_sb [SEARCH_DEPTH];
    logic [DATA_W-1:0] r_la [LA_DEPTH];
    logic [DATA_W-1:0] w_sbNext [SEARCH_DEPTH];
    logic [DATA_W-1:0] w_laNext [LA_DEPTH];
    logic [SB_CW-1:0]  r_sbCnt, w_sbCntNext;
    logic [LA_CW-1:0]  r_laCnt, w_cap;
    logic              r_termSeen, r_live;
    logic [SB_IW-1:0]  r_searchPos, r_bestPos, w_bestPos;
    logic [2:0]        r_bestLen, w_bestLen, w_len;
    logic [DATA_W-1:0] w_ref;
    logic              w_run, w_hit, w_ready, w_accept;
    int                w_sbSum;
    logic              r_outValid, r_finish;
    logic [3:0]        r_codePos;
    logic [2:0]        r_codeLen;
    logic [DATA_W-1:0] r_chardata;

    // r_live keeps in_ready low while reset is held and releases it one edge later.
    assign w_ready  = r_live && (r_state == ST_FILL) && (r_laCnt < LA_CW'(LA_DEPTH)) && !r_termSeen;
    assign w_accept = in_valid && w_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_FILL;
        else        r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_FILL:   if (r_laCnt == LA_CW'(LA_DEPTH) || (r_termSeen && r_laCnt != '0))
                           w_stateNext = ST_SEARCH;
            ST_SEARCH: if (r_searchPos == '0) w_stateNext = ST_EMIT;
            ST_EMIT:   w_stateNext = (r_chardata == TERM_CHAR) ? ST_DONE : ST_SHIFT;
            ST_SHIFT:  w_stateNext = ST_FILL;
            ST_DONE:   w_stateNext = ST_DONE;
            default:   w_stateNext = ST_FILL;
        endcase
    end

    // Match length at the current candidate; references past the search buffer wrap into the look-ahead.
    always_comb begin
        w_cap = r_laCnt - LA_CW'(1);
        w_len = '0;
        w_run = 1'b1;
        w_ref = '0;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (k <= int'(r_searchPos)) w_ref = r_sb[SB_IW'(int'(r_searchPos) - k)];
            else                        w_ref = r_la[LA_IW'(k - int'(r_searchPos) - 1)];
            if (w_run && (k < int'(w_cap)) && (r_la[LA_IW'(k)] == w_ref)) w_len = 3'(k + 1);
            else                                                          w_run = 1'b0;
        end
        w_hit     = int'(r_searchPos) < int'(r_sbCnt);
        w_bestPos = (w_hit && (w_len > r_bestLen)) ? r_searchPos : r_bestPos;
        w_bestLen = (w_hit && (w_len > r_bestLen)) ? w_len : r_bestLen;
    end

    always_comb begin
        for (int i = 0; i < SEARCH_DEPTH; i++) begin
            if (i <= int'(r_bestLen)) w_sbNext[i] = r_la[LA_IW'(int'(r_bestLen) - i)];
            else                      w_sbNext[i] = r_sb[SB_IW'(i - int'(r_bestLen) - 1)];
        end
        for (int i = 0; i < LA_DEPTH; i++) begin
            if (i + int'(r_bestLen) + 1 < LA_DEPTH) w_laNext[i] = r_la[LA_IW'(i + int'(r_bestLen) + 1)];
            else                                    w_laNext[i] = r_la[LA_IW'(i)];
        end
        w_sbSum     = int'(r_sbCnt) + int'(r_bestLen) + 1;
        w_sbCntNext = (w_sbSum > SEARCH_DEPTH) ? SB_CW'(SEARCH_DEPTH) : SB_CW'(w_sbSum);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SEARCH_DEPTH; i++) r_sb[i] <= '0;
            for (int i = 0; i < LA_DEPTH; i++)     r_la[i] <= '0;
            r_sbCnt     <= '0;
            r_laCnt     <= '0;
            r_termSeen  <= 1'b0;
            r_live      <= 1'b0;
            r_searchPos <= '0;
            r_bestPos   <= '0;
            r_bestLen   <= '0;
            r_outValid  <= 1'b0;
            r_finish    <= 1'b0;
            r_codePos   <= '0;
            r_codeLen   <= '0;
            r_chardata  <= '0;
        end else begin
            r_live     <= 1'b1;
            r_outValid <= 1'b0;
            case (r_state)
                ST_FILL: begin
                    if (w_accept) begin
                        r_la[LA_IW'(r_laCnt)] <= chardata_in;
                        r_laCnt               <= r_laCnt + LA_CW'(1);
                        if (chardata_in == TERM_CHAR) r_termSeen <= 1'b1;
                    end
                    r_searchPos <= SB_IW'(SEARCH_DEPTH - 1);
                    r_bestPos   <= '0;
                    r_bestLen   <= '0;
                end
                ST_SEARCH: begin
                    r_bestPos   <= w_bestPos;
                    r_bestLen   <= w_bestLen;
                    r_searchPos <= r_searchPos - SB_IW'(1);
                    if (r_searchPos == '0) begin
                        r_outValid <= 1'b1;
                        r_codePos  <= 4'(w_bestPos);
                        r_codeLen  <= w_bestLen;
                        r_chardata <= r_la[LA_IW'(w_bestLen)];
                        if (r_la[LA_IW'(w_bestLen)] == TERM_CHAR) r_finish <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    r_sb    <= w_sbNext;
                    r_la    <= w_laNext;
                    r_sbCnt <= w_sbCntNext;
                    r_laCnt <= r_laCnt - (LA_CW'(r_bestLen) + LA_CW'(1));
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = w_ready;
    assign out_valid = r_outValid;
    assign code_pos  = r_codePos;
    assign code_len  = r_codeLen;
    assign chardata  = r_chardata;
    assign finish    = r_finish;
endmodule

// File: tb/tb_lz77_encoder.sv
// Bench for lz77_encoder: each string is encoded by a whole-string LZ77 model into an
// expected-codeword queue, and a monitor compares every out_valid pulse against it.
module tb_lz77_encoder;
    localparam logic [7:0] TERM = 8'h24;

    typedef struct packed {
        logic [3:0] pos;
        logic [2:0] len;
        logic [7:0] ch;
    } codeT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       inValid = 1'b0;
    logic [7:0] charIn = 8'h00;
    logic       inReady, outValid, finishOut;
    logic [3:0] codePos;
    logic [2:0] codeLen;
    logic [7:0] charOut;

    codeT       expQ[$];
    logic [7:0] curStr[$];
    int         errors = 0;
    int         checks = 0;
    logic       prevValid = 1'b0;

    lz77_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (inValid),
        .chardata_in(charIn),
        .in_ready   (inReady),
        .out_valid  (outValid),
        .code_pos   (codePos),
        .code_len   (codeLen),
        .chardata   (charOut),
        .finish     (finishOut)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Plain LZ77 over the whole string: window = last 9 chars, look-ahead = next 8 chars.
    task automatic modelEncode();
        int   n, i, laCnt, bestPos, bestLen, len;
        codeT c;
        n = curStr.size();
        i = 0;
        while (i < n) begin
            laCnt   = (n - i < 8) ? n - i : 8;
            bestPos = 0;
            bestLen = 0;
            for (int p = 8; p >= 0; p--) begin
                if (p < i) begin
                    len = 0;
                    while (len < laCnt - 1 && len < 7 && curStr[i + len] == curStr[i + len - p - 1])
                        len++;
                    if (len > bestLen) begin
                        bestLen = len;
                        bestPos = p;
                    end
                end
            end
            c.pos = 4'(bestPos);
            c.len = 3'(bestLen);
            c.ch  = curStr[i + bestLen];
            expQ.push_back(c);
            i += bestLen + 1;
        end
    endtask

    always @(negedge clk) begin : monitor
        codeT e;
        if (reset) begin
            if (outValid) begin
                checkOutput("out_valid back-to-back", {31'd0, prevValid}, 32'd0);
                checkOutput("in_ready while emitting", {31'd0, inReady}, 32'd0);
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected codeword: got (%0d,%0d,0x%0h), expected none",
                             codePos, codeLen, charOut);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("code_pos", {28'd0, codePos}, {28'd0, e.pos});
                    checkOutput("code_len", {29'd0, codeLen}, {29'd0, e.len});
                    checkOutput("chardata", {24'd0, charOut}, {24'd0, e.ch});
                    checkOutput("finish with codeword", {31'd0, finishOut}, {31'd0, (e.ch == TERM)});
                end
            end
            prevValid = outValid;
        end else begin
            prevValid = 1'b0;
        end
    end

    task automatic setStr(input string s);
        curStr.delete();
        for (int i = 0; i < s.len(); i++) curStr.push_back(s[i]);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset   = 1'b0;
        inValid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset in_ready", {31'd0, inReady}, 32'd0);
        checkOutput("reset out_valid", {31'd0, outValid}, 32'd0);
        checkOutput("reset code_pos", {28'd0, codePos}, 32'd0);
        checkOutput("reset code_len", {29'd0, codeLen}, 32'd0);
        checkOutput("reset chardata", {24'd0, charOut}, 32'd0);
        checkOutput("reset finish", {31'd0, finishOut}, 32'd0);
        expQ.delete();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("in_ready after release", {31'd0, inReady}, 32'd1);
    endtask

    task automatic sendChar(input logic [7:0] c, input int gap);
        int waitCycles;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            inValid = 1'b0;
            charIn  = 8'($urandom);
        end
        @(negedge clk);
        inValid    = 1'b1;
        charIn     = c;
        waitCycles = 0;
        while (!inReady && waitCycles < 300) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!inReady) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept timeout: char 0x%0h waited %0d cycles, expected acceptance", c, waitCycles);
        end else begin
            @(posedge clk);
        end
    endtask

    // gapMode: 0 = continuous, 1 = idle cycle before every char, 2 = random idle cycles.
    task automatic applyStimulus(input int gapMode, input bit useModel);
        int gap;
        if (useModel) modelEncode();
        for (int i = 0; i < curStr.size(); i++) begin
            gap = (gapMode == 0) ? 0 : (gapMode == 1) ? 1 : int'($urandom_range(0, 2));
            sendChar(curStr[i], gap);
        end
        @(negedge clk);
        inValid = 1'b0;
    endtask

    task automatic waitFinish();
        int n;
        n = 0;
        while (!finishOut && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!finishOut) begin
            checks++;
            errors++;
            $display("[TB] FAIL finish timeout: finish=0 after %0d cycles, expected 1", n);
        end
        @(negedge clk);
        checkOutput("codewords outstanding", expQ.size(), 32'd0);
        inValid = 1'b1;
        charIn  = "a";
        repeat (3) @(negedge clk);
        checkOutput("DONE in_ready", {31'd0, inReady}, 32'd0);
        checkOutput("DONE out_valid", {31'd0, outValid}, 32'd0);
        checkOutput("DONE finish held", {31'd0, finishOut}, 32'd1);
        checkOutput("DONE chardata held", {24'd0, charOut}, {24'd0, TERM});
        inValid = 1'b0;
    endtask

    initial begin
        int len;
        $display("[TB] starting lz77_encoder bench");
        doReset();

        setStr("abcabc$"); applyStimulus(0, 1'b1); waitFinish(); doReset();
        setStr("aaaa$");   applyStimulus(0, 1'b1); waitFinish(); doReset();
        setStr("aaba$");   applyStimulus(0, 1'b1); waitFinish(); doReset();

        curStr.delete();
        for (int i = 0; i < 20; i++) curStr.push_back("a");
        curStr.push_back(TERM);
        applyStimulus(0, 1'b1); waitFinish(); doReset();

        setStr("ab$"); applyStimulus(1, 1'b1); waitFinish(); doReset();

        setStr("abcabc$"); applyStimulus(0, 1'b0);
        repeat (2) @(negedge clk);
        doReset();
        setStr("aa$"); applyStimulus(0, 1'b1); waitFinish(); doReset();

        for (int r = 0; r < 30; r++) begin
            curStr.delete();
            len = int'($urandom_range(1, 24));
            for (int i = 0; i < len; i++) curStr.push_back(8'("a" + $urandom_range(0, (r % 2 == 0) ? 1 : 3)));
            curStr.push_back(TERM);
            applyStimulus(int'($urandom_range(0, 2)), 1'b1);
            waitFinish();
            doReset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
